// File: rtl/mic1_mem_pkg.sv
// Shared types and helpers for the MIC-1 memory access controller.
package mic1_mem_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned LANE_W     = 2;
    localparam int unsigned DEF_RD_LAT = 1;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        ISSUE_FETCH = 2'd1,
        DRAIN       = 2'd2
    } state_e;

    typedef enum logic {
        DST_MDR = 1'b0,
        DST_MBR = 1'b1
    } dst_e;

    typedef struct packed {
        logic              valid;
        dst_e              dst;
        logic [LANE_W-1:0] lane;
    } rd_tag_t;

    // Little-endian byte lane select out of a memory word.
    function automatic logic [7:0] lane_byte(input logic [WORD_W-1:0] word,
                                             input logic [LANE_W-1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mic1_mem_ctrl_if.sv
// Main-memory port between the access controller (master) and memory (slave).
interface mic1_mem_ctrl_if #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 32
);
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ren;
    logic [ADDR_W-1:0] mem_raddr;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_wen, mem_waddr, mem_wdata, mem_ren, mem_raddr,
        input  mem_rdata
    );

    modport slave (
        input  mem_wen, mem_waddr, mem_wdata, mem_ren, mem_raddr,
        output mem_rdata
    );
endinterface

// File: rtl/mic1_rd_tag_pipe.sv
// Shift register carrying read destination tags alongside the memory latency.
module mic1_rd_tag_pipe
    import mic1_mem_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_RD_LAT + 1
) (
    input  logic    clk,
    input  logic    rst_n,
    input  rd_tag_t i_tag,
    output rd_tag_t o_head,
    output logic    o_empty_nxt_c
);

    rd_tag_t r_stage [DEPTH];

    // Shift tags one stage per clock; reset drops every in-flight tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_tag;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_head = r_stage[DEPTH-1];

    // Pipe is empty after the next shift when nothing sits behind the head (no push assumed).
    always_comb begin
        o_empty_nxt_c = 1'b1;
        for (int unsigned i = 0; i < DEPTH - 1; i++) begin
            if (r_stage[i].valid) begin
                o_empty_nxt_c = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mic1_mem_ctrl.sv
// MIC-1 memory access controller: turns rd/wr/fetch into main-memory cycles
// and steers returning read data into MDR (word) or MBR (byte).
module mic1_mem_ctrl
    import mic1_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = DEF_RD_LAT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rd_i,
    input  logic                wr_i,
    input  logic                fetch_i,
    input  logic [ADDR_W-1:0]   mar_i,
    input  logic [DATA_W-1:0]   mdr_i,
    input  logic [ADDR_W+1:0]   pc_i,
    mic1_mem_ctrl_if.master     mem,
    output logic [DATA_W-1:0]   mdr_o,
    output logic                mdr_vld,
    output logic [7:0]          mbr_o,
    output logic                mbr_vld,
    output logic                busy,
    output logic                err_o
);

    localparam int unsigned PIPE_DEPTH = RD_LAT + 1;

    state_e              r_state,       w_state_nxt;
    logic                r_wen,         w_wen_nxt;
    logic [ADDR_W-1:0]   r_waddr,       w_waddr_nxt;
    logic [DATA_W-1:0]   r_wdata,       w_wdata_nxt;
    logic                r_ren,         w_ren_nxt;
    logic [ADDR_W-1:0]   r_raddr,       w_raddr_nxt;
    logic [DATA_W-1:0]   r_mdr,         w_mdr_nxt;
    logic                r_mdr_vld,     w_mdr_vld_nxt;
    logic [7:0]          r_mbr,         w_mbr_nxt;
    logic                r_mbr_vld,     w_mbr_vld_nxt;
    logic                r_busy,        w_busy_nxt;
    logic                r_err,         w_err_nxt;
    logic [ADDR_W-1:0]   r_fetch_addr,  w_fetch_addr_nxt;
    logic [LANE_W-1:0]   r_fetch_lane,  w_fetch_lane_nxt;

    rd_tag_t             w_push_tag;
    rd_tag_t             w_head_tag;
    logic                w_pipe_empty_nxt;
    logic                w_any_req;

    assign w_any_req = rd_i | wr_i | fetch_i;

    mic1_rd_tag_pipe #(
        .DEPTH         (PIPE_DEPTH)
    ) u_tag_pipe (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_tag         (w_push_tag),
        .o_head        (w_head_tag),
        .o_empty_nxt_c (w_pipe_empty_nxt)
    );

    // Next-state, request issue and read-data capture.
    always_comb begin
        w_state_nxt      = r_state;
        w_wen_nxt        = 1'b0;
        w_waddr_nxt      = r_waddr;
        w_wdata_nxt      = r_wdata;
        w_ren_nxt        = 1'b0;
        w_raddr_nxt      = r_raddr;
        w_mdr_nxt        = r_mdr;
        w_mdr_vld_nxt    = 1'b0;
        w_mbr_nxt        = r_mbr;
        w_mbr_vld_nxt    = 1'b0;
        w_err_nxt        = 1'b0;
        w_fetch_addr_nxt = r_fetch_addr;
        w_fetch_lane_nxt = r_fetch_lane;
        w_push_tag       = '0;

        // Head of the tag pipe lines up with the returning memory word.
        if (w_head_tag.valid) begin
            if (w_head_tag.dst == DST_MDR) begin
                w_mdr_nxt     = mem.mem_rdata;
                w_mdr_vld_nxt = 1'b1;
            end else begin
                w_mbr_nxt     = lane_byte(WORD_W'(mem.mem_rdata), w_head_tag.lane);
                w_mbr_vld_nxt = 1'b1;
            end
        end

        case (r_state)
            IDLE: begin
                if (rd_i && wr_i) begin
                    // Illegal combination: drop everything including fetch.
                    w_err_nxt = 1'b1;
                end else begin
                    if (wr_i) begin
                        w_wen_nxt   = 1'b1;
                        w_waddr_nxt = mar_i;
                        w_wdata_nxt = mdr_i;
                    end
                    if (rd_i) begin
                        w_ren_nxt   = 1'b1;
                        w_raddr_nxt = mar_i;
                        w_push_tag  = '{valid: 1'b1, dst: DST_MDR, lane: '0};
                        if (fetch_i) begin
                            // Fetch read is deferred one cycle behind the word read.
                            w_fetch_addr_nxt = pc_i[ADDR_W+1:2];
                            w_fetch_lane_nxt = pc_i[1:0];
                            w_state_nxt      = ISSUE_FETCH;
                        end else begin
                            w_state_nxt = DRAIN;
                        end
                    end else if (fetch_i) begin
                        w_ren_nxt   = 1'b1;
                        w_raddr_nxt = pc_i[ADDR_W+1:2];
                        w_push_tag  = '{valid: 1'b1, dst: DST_MBR, lane: pc_i[1:0]};
                        w_state_nxt = DRAIN;
                    end
                end
            end
            ISSUE_FETCH: begin
                w_ren_nxt   = 1'b1;
                w_raddr_nxt = r_fetch_addr;
                w_push_tag  = '{valid: 1'b1, dst: DST_MBR, lane: r_fetch_lane};
                w_err_nxt   = w_any_req;
                w_state_nxt = DRAIN;
            end
            DRAIN: begin
                w_err_nxt = w_any_req;
                if (w_pipe_empty_nxt) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_wen        <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
            r_ren        <= 1'b0;
            r_raddr      <= '0;
            r_mdr        <= '0;
            r_mdr_vld    <= 1'b0;
            r_mbr        <= '0;
            r_mbr_vld    <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
            r_fetch_addr <= '0;
            r_fetch_lane <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_wen        <= w_wen_nxt;
            r_waddr      <= w_waddr_nxt;
            r_wdata      <= w_wdata_nxt;
            r_ren        <= w_ren_nxt;
            r_raddr      <= w_raddr_nxt;
            r_mdr        <= w_mdr_nxt;
            r_mdr_vld    <= w_mdr_vld_nxt;
            r_mbr        <= w_mbr_nxt;
            r_mbr_vld    <= w_mbr_vld_nxt;
            r_busy       <= w_busy_nxt;
            r_err        <= w_err_nxt;
            r_fetch_addr <= w_fetch_addr_nxt;
            r_fetch_lane <= w_fetch_lane_nxt;
        end
    end

    assign mem.mem_wen   = r_wen;
    assign mem.mem_waddr = r_waddr;
    assign mem.mem_wdata = r_wdata;
    assign mem.mem_ren   = r_ren;
    assign mem.mem_raddr = r_raddr;
    assign mdr_o         = r_mdr;
    assign mdr_vld       = r_mdr_vld;
    assign mbr_o         = r_mbr;
    assign mbr_vld       = r_mbr_vld;
    assign busy          = r_busy;
    assign err_o         = r_err;

endmodule
